// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver, centre-sampling each bit of a start/DBIT/stop frame
//   clk          system clock, all state on rising edge
//   reset        asynchronous, active-high reset
//   rx           serial line, asynchronous to clk, idles high
//   s_tick       one-clk pulse at 16x baud rate
//   dout         last received data word (holds until next frame completes)
//   rx_done_tick one-clk pulse the cycle after a frame completes
//   frame_err    stop bit was sampled low on the last completed frame
//   busy         high whenever the receiver is not idle
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            busy
);
    typedef enum logic [1:0] {idle, start, data, stop} state_t;
    state_t          state_reg, state_next;
    logic [4:0]      s_reg, s_next;
    logic [2:0]      n_reg, n_next;
    logic [DBIT-1:0] b_reg, b_next, dout_next;
    logic            rx_m, rx_s, done_next, err_next, busy_next;
    // Synchroniser flops reset to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset)
        if (reset) {rx_m, rx_s} <= 2'b11;
        else       {rx_m, rx_s} <= {rx, rx_m};
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_reg    <= idle;
            s_reg        <= '0;
            n_reg        <= '0;
            b_reg        <= '0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_reg    <= state_next;
            s_reg        <= s_next;
            n_reg        <= n_next;
            b_reg        <= b_next;
            dout         <= dout_next;
            rx_done_tick <= done_next;
            frame_err    <= err_next;
            busy         <= busy_next;
        end
    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        n_next     = n_reg;
        b_next     = b_reg;
        dout_next  = dout;
        err_next   = frame_err;
        done_next  = 1'b0;
        case (state_reg)
            // Leaving idle needs no tick so a start bit right after a stop is never missed.
            idle:
                if (!rx_s) begin
                    state_next = start;
                    s_next     = '0;
                end
            // Half a bit into the start bit: a line back high means it was a glitch.
            start:
                if (s_tick) begin
                    if (s_reg == 5'd7) begin
                        if (!rx_s) begin
                            state_next = data;
                            s_next     = '0;
                            n_next     = '0;
                        end else
                            state_next = idle;
                    end else
                        s_next = s_reg + 5'd1;
                end
            data:
                if (s_tick) begin
                    if (s_reg == 5'd15) begin
                        s_next = '0;
                        b_next = {rx_s, b_reg[DBIT-1:1]};
                        if (n_reg == 3'(DBIT - 1)) state_next = stop;
                        else                       n_next = n_reg + 3'd1;
                    end else
                        s_next = s_reg + 5'd1;
                end
            // Frames with a bad stop bit still deliver their data, flagged by frame_err.
            stop:
                if (s_tick) begin
                    if (s_reg == 5'(SB_TICK - 1)) begin
                        state_next = idle;
                        dout_next  = b_reg;
                        err_next   = ~rx_s;
                        done_next  = 1'b1;
                    end else
                        s_next = s_reg + 5'd1;
                end
            default: state_next = idle;
        endcase
        busy_next = state_next != idle;
    end
endmodule
